tjmono_hit_decoder: RTL

Downstream consumer of the TJ-Monopix data-RX FIFO. Pops 32-bit words, checks the channel identifier and the 2-bit sub-word tag, and rebuilds the 112-bit hit frame from four 28-bit slices. Decodes the frame into hit fields, computes ToT, and presents one hit per valid/ready handshake to the on-FPGA histogrammer/cluster stage. Error and hit counters are exposed as ports for the bus register file.

---
 rtl/tjmono_hit_decoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tjmono_hit_decoder.sv
// Rebuilds 112-bit TJ-Monopix hit frames from four tagged 32-bit FIFO words and
// presents one decoded hit per valid/ready handshake, with hit and error counters.
module tjmono_hit_decoder #(
    parameter logic [1:0] IDENTIFIER = 2'b00,
    parameter int         CNT_WIDTH  = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 RST,
    input  logic [31:0]          IN_DATA,
    input  logic                 IN_EMPTY,
    output logic                 IN_READ,
    output logic                 HIT_VALID,
    input  logic                 HIT_READY,
    output logic [5:0]           HIT_COL,
    output logic [8:0]           HIT_ROW,
    output logic [5:0]           HIT_LE,
    output logic [5:0]           HIT_TE,
    output logic [5:0]           HIT_TOT,
    output logic                 HIT_NOISE,
    output logic [51:0]          HIT_TS,
    output logic [29:0]          HIT_TOKEN_CNT,
    output logic [31:0]          HIT_CNT,
    output logic [CNT_WIDTH-1:0] FRAME_ERR_CNT,
    output logic [CNT_WIDTH-1:0] ID_ERR_CNT
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]   exp_tag;
    logic [83:0]  part_buf;

    logic [1:0]   word_id;
    logic [1:0]   word_tag;
    logic [27:0]  word_slice;
    logic         id_ok;
    logic         completes;
    logic         stall;
    logic [111:0] frame;

    assign word_id    = IN_DATA[31:30];
    assign word_tag   = IN_DATA[29:28];
    assign word_slice = IN_DATA[27:0];
    assign id_ok      = (word_id == IDENTIFIER);
    assign completes  = id_ok && (exp_tag == 2'd3) && (word_tag == 2'd3);

    // Output handshake: a record transfers on every clock where HIT_VALID and
    // HIT_READY are both high; while HIT_VALID=1 and HIT_READY=0 the record is
    // frozen, so only the frame-completing word must wait, earlier slices flow.
    assign stall   = completes && HIT_VALID && !HIT_READY;
    assign IN_READ = !RST && !IN_EMPTY && !stall;

    assign frame = {word_slice, part_buf};

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            exp_tag       <= 2'd0;
            part_buf      <= '0;
            HIT_VALID     <= 1'b0;
            HIT_COL       <= '0;
            HIT_ROW       <= '0;
            HIT_LE        <= '0;
            HIT_TE        <= '0;
            HIT_TOT       <= '0;
            HIT_NOISE     <= 1'b0;
            HIT_TS        <= '0;
            HIT_TOKEN_CNT <= '0;
            HIT_CNT       <= '0;
            FRAME_ERR_CNT <= '0;
            ID_ERR_CNT    <= '0;
        end else begin
            if (HIT_VALID && HIT_READY) begin
                HIT_VALID <= 1'b0;
                HIT_CNT   <= HIT_CNT + 32'd1;
            end

            if (IN_READ) begin
                if (!id_ok) begin
                    if (ID_ERR_CNT != '1)
                        ID_ERR_CNT <= ID_ERR_CNT + CNT_ONE;
                end else if (word_tag == exp_tag) begin
                    case (exp_tag)
                        2'd0: begin
                            part_buf[27:0] <= word_slice;
                            exp_tag        <= 2'd1;
                        end
                        2'd1: begin
                            part_buf[55:28] <= word_slice;
                            exp_tag         <= 2'd2;
                        end
                        2'd2: begin
                            part_buf[83:56] <= word_slice;
                            exp_tag         <= 2'd3;
                        end
                        default: begin
                            // Later assignment overrides the handshake clear above,
                            // so a back-to-back record keeps HIT_VALID high.
                            HIT_VALID     <= 1'b1;
                            HIT_COL       <= frame[5:0];
                            HIT_ROW       <= frame[14:6];
                            HIT_TE        <= frame[20:15];
                            HIT_LE        <= frame[26:21];
                            HIT_TOT       <= frame[20:15] - frame[26:21];
                            HIT_NOISE     <= frame[29];
                            HIT_TS        <= frame[81:30];
                            HIT_TOKEN_CNT <= frame[111:82];
                            exp_tag       <= 2'd0;
                        end
                    endcase
                end else if (word_tag == 2'd0) begin
                    // Out-of-order start tag: treat it as a fresh frame.
                    if (FRAME_ERR_CNT != '1)
                        FRAME_ERR_CNT <= FRAME_ERR_CNT + CNT_ONE;
                    part_buf[27:0] <= word_slice;
                    exp_tag        <= 2'd1;
                end else begin
                    if (FRAME_ERR_CNT != '1)
                        FRAME_ERR_CNT <= FRAME_ERR_CNT + CNT_ONE;
                    exp_tag <= 2'd0;
                end
            end
        end
    end

endmodule
